// File: rtl/permutation_driver_pkg.sv
// rtl/permutation_driver_pkg.sv - shared state encoding and width helper for the permutation driver
package permutation_driver_pkg;

   typedef enum logic [2:0] {
      LOAD    = 3'd0,
      START   = 3'd1,
      WAIT_LO = 3'd2,
      WAIT_HI = 3'd3,
      SEND    = 3'd4
   } state_e;

   // Bits needed to hold values 0..value-1 (at least 1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      if (r == 0) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/permutation_driver_counter.sv
// rtl/permutation_driver_counter.sv - mod-N word index with clear, enable and last-word flag
module perm_word_counter
   import permutation_driver_pkg::*;
#(
   parameter int N = 4,
   parameter int W = clog2(N)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] idx_o,
   output logic         last_o
);

   logic [W-1:0] idx_q;
   logic [W-1:0] idx_d;

   assign last_o = (idx_q == W'(N - 1));
   assign idx_o  = idx_q;

   // Wrap is explicit so non-power-of-two N never walks past the last word.
   always_comb begin
      idx_d = idx_q;
      if (clr_i) begin
         idx_d = '0;
      end else if (en_i) begin
         idx_d = last_o ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/permutation_driver.sv
// rtl/permutation_driver.sv - collects a block, starts the permutation engine, streams back its result
module permutation_driver
   import permutation_driver_pkg::*;
#(
   parameter int WORD_W  = 8,
   parameter int NWORDS  = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WORD_W-1:0]        inData,
   input  logic                     inValid,
   output logic                     inReady,
   output logic                     permStart,
   input  logic                     permReady,
   output logic [WORD_W*NWORDS-1:0] permDin,
   input  logic [WORD_W*NWORDS-1:0] permDout,
   output logic [WORD_W-1:0]        outData,
   output logic                     outValid,
   input  logic                     outReady,
   output logic                     busy,
   output logic                     err
);

   localparam int IDX_W  = clog2(NWORDS);
   localparam int WD_W   = clog2(TIMEOUT + 1);
   localparam int DATA_W = WORD_W * NWORDS;

   state_e             state_q, state_d;
   logic [WD_W-1:0]    wd_q, wd_d, wd_inc;
   logic [DATA_W-1:0]  in_buf_q, in_buf_d;
   logic [DATA_W-1:0]  out_buf_q, out_buf_d;
   logic               err_q, err_d;
   logic [IDX_W-1:0]   idx;
   logic               idx_last;
   logic               cnt_en;
   logic               cnt_clr;

   // One index serves both collection and streaming; the two phases never overlap.
   perm_word_counter #(
      .N (NWORDS),
      .W (IDX_W)
   ) u_idx (
      .clk_i  (clk),
      .rst_i  (rst),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .idx_o  (idx),
      .last_o (idx_last)
   );

   assign wd_inc = (wd_q == WD_W'(TIMEOUT)) ? wd_q : wd_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      wd_d      = wd_q;
      in_buf_d  = in_buf_q;
      out_buf_d = out_buf_q;
      err_d     = err_q;
      cnt_en    = 1'b0;
      cnt_clr   = 1'b0;
      case (state_q)
         LOAD: begin
            if (inValid) begin
               in_buf_d[idx*WORD_W +: WORD_W] = inData;
               cnt_en = 1'b1;
               if (idx == '0) begin
                  err_d = 1'b0;
               end
               if (idx_last) begin
                  state_d = START;
               end
            end
         end
         START: begin
            wd_d    = '0;
            state_d = WAIT_LO;
         end
         WAIT_LO, WAIT_HI: begin
            // Completion is only a low-then-high sequence; a high level in WAIT_LO is not done.
            if (state_q == WAIT_LO && !permReady) begin
               state_d = WAIT_HI;
            end else if (state_q == WAIT_HI && permReady) begin
               out_buf_d = permDout;
               state_d   = SEND;
            end else begin
               wd_d = wd_inc;
               if (wd_inc == WD_W'(TIMEOUT)) begin
                  err_d   = 1'b1;
                  cnt_clr = 1'b1;
                  state_d = LOAD;
               end
            end
         end
         SEND: begin
            if (outReady) begin
               cnt_en = 1'b1;
               if (idx_last) begin
                  state_d = LOAD;
               end
            end
         end
         default: begin
            cnt_clr = 1'b1;
            state_d = LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= LOAD;
         wd_q      <= '0;
         in_buf_q  <= '0;
         out_buf_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wd_q      <= wd_d;
         in_buf_q  <= in_buf_d;
         out_buf_q <= out_buf_d;
         err_q     <= err_d;
      end
   end

   assign inReady   = (state_q == LOAD);
   assign permStart = (state_q == START);
   assign outValid  = (state_q == SEND);
   assign busy      = (state_q != LOAD);
   assign err       = err_q;
   assign permDin   = in_buf_q;
   assign outData   = (state_q == SEND) ? out_buf_q[idx*WORD_W +: WORD_W] : '0;

endmodule

// File: tb/tb_permutation_driver.sv
// tb/tb_permutation_driver.sv - directed table-driven bench for permutation_driver
module tb_permutation_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  inData = 8'h00;
   logic        inValid = 1'b0;
   logic        inReady;
   logic        permStart;
   logic        permReady = 1'b1;
   logic [31:0] permDin;
   logic [31:0] permDout = 32'h0;
   logic [7:0]  outData;
   logic        outValid;
   logic        outReady = 1'b1;
   logic        busy;
   logic        err;

   permutation_driver #(
      .WORD_W  (8),
      .NWORDS  (4),
      .TIMEOUT (255)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .inData    (inData),
      .inValid   (inValid),
      .inReady   (inReady),
      .permStart (permStart),
      .permReady (permReady),
      .permDin   (permDin),
      .permDout  (permDout),
      .outData   (outData),
      .outValid  (outValid),
      .outReady  (outReady),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] din;
      logic [31:0] dout;
   } vec_t;

   vec_t vecs[4];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Engine model: drops ready after start, returns inverted block 10 cycles later.
   int          eng_mode = 0;
   int          eng_cnt = 0;
   logic [31:0] eng_din = 32'h0;
   always @(posedge clk) begin
      if (eng_cnt > 0) begin
         eng_cnt <= eng_cnt - 1;
         if (eng_cnt == 1) begin
            permReady <= 1'b1;
            permDout  <= ~eng_din;
         end
      end else if (permStart && eng_mode == 0) begin
         permReady <= 1'b0;
         eng_cnt   <= 10;
         eng_din   <= permDin;
      end
   end

   // Downstream sink: optional stall at one word index, collects transferred words.
   logic [7:0] outq[$];
   int         start_cnt = 0;
   int         ov_cnt = 0;
   int         stall_word = -1;
   int         stall_left = 0;
   int         stall_seen = 0;
   logic [7:0] stall_exp = 8'h00;
   always @(negedge clk) begin
      if (permStart) start_cnt++;
      if (outValid) ov_cnt++;
      if (outValid && stall_left > 0 && outq.size() == stall_word) begin
         outReady = 1'b0;
         stall_left--;
         stall_seen++;
         chk("stall_hold", {24'h0, outData}, {24'h0, stall_exp});
      end else begin
         outReady = 1'b1;
      end
      if (outValid && outReady) outq.push_back(outData);
   end

   task automatic push_block(input logic [31:0] din, input bit gaps, output logic err_first);
      int k;
      int guard;
      bit tog;
      bit rec;
      int s0;
      k = 0; guard = 0; tog = 1'b0; rec = 1'b0; err_first = 1'bx;
      s0 = start_cnt;
      while (k < 4 && guard < 100) begin
         @(negedge clk);
         guard++;
         if (k == 1 && !rec) begin
            err_first = err;
            rec = 1'b1;
         end
         if (gaps && tog) begin
            inValid = 1'b0;
            inData  = 8'h5A;
         end else begin
            inValid = 1'b1;
            inData  = din[k*8 +: 8];
         end
         tog = ~tog;
         if (inValid && inReady) begin
            k++;
            if (k == 4) chk("no_early_start", start_cnt, s0);
         end
      end
      chk("push_done", k, 4);
      @(negedge clk);
      inValid = 1'b0;
      chk("start_pulse", {31'h0, permStart}, 32'h1);
      chk("perm_din", permDin, din);
      chk("in_backpressure", {31'h0, inReady}, 32'h0);
      @(negedge clk);
      chk("start_one_cycle", {31'h0, permStart}, 32'h0);
   endtask

   task automatic wait_out(input int n);
      int g;
      g = 0;
      while (outq.size() < n && g < 300) begin
         @(negedge clk);
         g++;
      end
      @(negedge clk);
      chk("out_count", outq.size(), n);
      chk("busy_idle", {31'h0, busy}, 32'h0);
      chk("out_valid_idle", {31'h0, outValid}, 32'h0);
   endtask

   task automatic check_out(input logic [31:0] dout);
      for (int i = 0; i < 4; i++) begin
         if (i < outq.size()) chk("out_word", {24'h0, outq[i]}, {24'h0, dout[i*8 +: 8]});
         else chk("out_word_missing", i, 32'hFFFF_FFFF);
      end
      outq.delete();
   endtask

   task automatic chk_reset_outputs();
      chk("rst_in_ready", {31'h0, inReady}, 32'h1);
      chk("rst_out_valid", {31'h0, outValid}, 32'h0);
      chk("rst_perm_start", {31'h0, permStart}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_perm_din", permDin, 32'h0);
      chk("rst_out_data", {24'h0, outData}, 32'h0);
   endtask

   task automatic wait_engine_idle();
      int g;
      g = 0;
      while ((eng_cnt != 0 || !permReady) && g < 100) begin
         @(negedge clk);
         g++;
      end
      chk("engine_idle", {31'h0, permReady}, 32'h1);
   endtask

   initial begin
      logic ef;
      int   s0;
      int   n;
      int   ov0;
      vecs[0] = '{din: 32'h44332211, dout: 32'hBBCCDDEE};
      vecs[1] = '{din: 32'hA55A0FF0, dout: 32'h5AA5F00F};
      vecs[2] = '{din: 32'h01020304, dout: 32'hFEFDFCFB};
      vecs[3] = '{din: 32'hFF000080, dout: 32'h00FFFF7F};

      repeat (3) @(negedge clk);
      chk_reset_outputs();
      chk("rst_err", {31'h0, err}, 32'h0);
      rst = 1'b0;

      // Back-to-back blocks from the table.
      s0 = start_cnt;
      for (int i = 0; i < 4; i++) begin
         push_block(vecs[i].din, 1'b0, ef);
         wait_out(4);
         check_out(vecs[i].dout);
      end
      chk("start_pulses", start_cnt - s0, 4);

      // Upstream gaps with garbage on idle cycles.
      push_block(vecs[1].din, 1'b1, ef);
      wait_out(4);
      check_out(vecs[1].dout);

      // Downstream stall at word 1.
      stall_word = 1; stall_left = 5; stall_exp = 8'hDD; stall_seen = 0;
      push_block(vecs[0].din, 1'b0, ef);
      wait_out(4);
      check_out(vecs[0].dout);
      chk("stall_cycles", stall_seen, 5);

      // Engine never drops ready.
      eng_mode = 1;
      ov0 = ov_cnt;
      push_block(vecs[2].din, 1'b0, ef);
      n = 0;
      while (!err && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_cycles", n, 255);
      chk("timeout_err", {31'h0, err}, 32'h1);
      chk("timeout_load", {31'h0, inReady}, 32'h1);
      chk("timeout_no_output", ov_cnt - ov0, 0);
      chk("timeout_queue", outq.size(), 0);
      eng_mode = 0;
      push_block(vecs[3].din, 1'b0, ef);
      chk("err_cleared", {31'h0, ef}, 32'h0);
      wait_out(4);
      check_out(vecs[3].dout);

      // Reset while waiting for the engine to finish.
      push_block(vecs[1].din, 1'b0, ef);
      @(negedge clk);
      chk("in_wait_hi", {31'h0, busy}, 32'h1);
      rst = 1'b1;
      #1;
      chk_reset_outputs();
      @(negedge clk);
      rst = 1'b0;
      wait_engine_idle();
      repeat (3) @(negedge clk);
      chk("rst_hi_no_output", outq.size(), 0);

      // Reset while word 2 is being offered.
      stall_word = 2; stall_left = 1000; stall_exp = 8'hCC;
      push_block(vecs[0].din, 1'b0, ef);
      n = 0;
      while (!(outq.size() == 2 && outValid && !outReady) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reached_send_w2", {31'h0, outValid}, 32'h1);
      rst = 1'b1;
      #1;
      chk_reset_outputs();
      stall_left = 0;
      @(negedge clk);
      rst = 1'b0;
      outq.delete();
      wait_engine_idle();
      push_block(vecs[2].din, 1'b0, ef);
      wait_out(4);
      check_out(vecs[2].dout);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
